// File: rtl/booth_mul_seq_pkg.sv
// Shared definitions for the sequential radix-4 Booth multiplier:
// FSM state encodings, Booth digit codes and the triplet recoder.
package booth_mul_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    DIG_ZERO = 3'd0,
    DIG_P1   = 3'd1,
    DIG_P2   = 3'd2,
    DIG_M1   = 3'd3,
    DIG_M2   = 3'd4
  } digit_t;

  // Triplet is {b[2j+1], b[2j], b[2j-1]}.
  function automatic digit_t booth_digit(input logic [2:0] trip);
    digit_t dig;
    case (trip)
      3'b001, 3'b010: dig = DIG_P1;
      3'b011:         dig = DIG_P2;
      3'b100:         dig = DIG_M2;
      3'b101, 3'b110: dig = DIG_M1;
      default:        dig = DIG_ZERO;
    endcase
    return dig;
  endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// Radix-4 Booth partial-product selector: maps one recoded triplet and the
// extended multiplicand onto a signed partial product one bit wider.
module booth_pp_sel
  import booth_mul_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       trip,
  input  logic [WIDTH+1:0] a_ext,
  output logic [WIDTH+2:0] pp
);

  logic [WIDTH+2:0] a1;
  logic [WIDTH+2:0] a2;

  assign a1 = {a_ext[WIDTH+1], a_ext};
  assign a2 = {a_ext, 1'b0};

  always_comb begin
    pp = '0;
    case (booth_digit(trip))
      DIG_P1:  pp = a1;
      DIG_P2:  pp = a2;
      DIG_M1:  pp = -a1;
      DIG_M2:  pp = -a2;
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier retiring one digit per clock, with a
// start/busy/done handshake and registered HI/LO product halves.
module booth_mul_seq
  import booth_mul_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int N  = WIDTH + 2;
  localparam int D  = N / 2;
  localparam int CW = $clog2(D + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(D - 1);

  state_t           state_reg, state_next;
  logic [N-1:0]     a_reg;
  logic [2*N:0]     prod_reg;
  logic             bm1_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg;

  logic [N-1:0] a_in_ext, b_in_ext;
  logic [2:0]   trip;
  logic [N:0]   pp;
  logic [N:0]   acc_sum;
  logic [2*N:0] prod_shift;
  logic         accept, last;

  // Two extra bits make full-range unsigned operands exact in signed Booth.
  assign a_in_ext = sgn ? {{2{A[WIDTH-1]}}, A} : {2'b00, A};
  assign b_in_ext = sgn ? {{2{B[WIDTH-1]}}, B} : {2'b00, B};

  assign trip       = {prod_reg[1:0], bm1_reg};
  assign acc_sum    = prod_reg[2*N:N] + pp;
  assign prod_shift = {{2{acc_sum[N]}}, acc_sum, prod_reg[N-1:2]};

  assign accept = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  assign last   = (state_reg == ST_RUN) && (cnt_reg == CNT_LAST);

  booth_pp_sel #(.WIDTH(WIDTH)) u_pp_sel (
    .trip  (trip),
    .a_ext (a_reg),
    .pp    (pp)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (cnt_reg == CNT_LAST) state_next = ST_DONE;
      ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == ST_RUN);
    done = (state_reg == ST_DONE);
    HI   = hi_reg;
    LO   = lo_reg;
  end

  // Product register: accumulator in the upper N+1 bits, multiplier below it
  // shifting out two bits per digit; bm1_reg carries the previous top bit.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      a_reg    <= '0;
      prod_reg <= '0;
      bm1_reg  <= 1'b0;
      cnt_reg  <= '0;
      hi_reg   <= '0;
      lo_reg   <= '0;
    end else if (accept) begin
      a_reg    <= a_in_ext;
      prod_reg <= {{(N+1){1'b0}}, b_in_ext};
      bm1_reg  <= 1'b0;
      cnt_reg  <= '0;
    end else if (state_reg == ST_RUN) begin
      prod_reg <= prod_shift;
      bm1_reg  <= prod_reg[1];
      cnt_reg  <= cnt_reg + CW'(1);
      if (last) begin
        hi_reg <= prod_shift[2*WIDTH-1:WIDTH];
        lo_reg <= prod_shift[WIDTH-1:0];
      end
    end
  end

endmodule
